// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: acknowledges each byte with a one-cycle
// rx_done pulse and queues it in a first-word-fall-through FIFO with overrun and fill-level irq.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  rx_done,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovr,
  input  logic                  ovr_clr,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH_C = (DEPTH_LOG2 + 1)'(THRESH);

  typedef enum logic {IDLE, ACK} state_t;

  logic [7:0]            mem_q [DEPTH];
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rx_done_q, rx_done_d;
  logic                  ovr_q, ovr_d;
  logic                  irq_q, irq_d;
  logic                  accept, pop, wr_en, drop;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovr_d     = ovr_q;
    accept    = (state_q == IDLE) && rx_rdy;
    pop       = rd_en && (count_q != '0);
    // A pop on the same edge frees the slot, so a full FIFO can still take the byte.
    wr_en     = accept && ((count_q != DEPTH_C) || pop);
    drop      = accept && !wr_en;
    rx_done_d = accept;

    case (state_q)
      IDLE:    if (rx_rdy) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase

    irq_d = (count_d >= THRESH_C);

    if (drop)         ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_done_q <= 1'b0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_done_q <= rx_done_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_done = rx_done_q;
  assign ovr     = ovr_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: per-cycle vector table for the handshake,
// scoreboard queue for fill/wrap/overrun ordering, plus hand-written corner sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovr;
  logic       ovr_clr;
  logic       irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4), .THRESH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovr     (ovr),
    .ovr_clr (ovr_clr),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic model_ovr = 1'b0;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       exp_done;
    logic [4:0] exp_count;
    logic [7:0] exp_rdd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Receiver model: holds rx_rdy until rx_done is seen, then drops it.
  task automatic send(input logic [7:0] d, input logic clr);
    bit seen = 0;
    rx_rdy  = 1'b1;
    rx_data = d;
    ovr_clr = clr;
    for (int n = 0; n < 8 && !seen; n++) begin
      cyc();
      if (rx_done === 1'b1) seen = 1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    if (sb.size() < 16) begin
      sb.push_back(d);
      if (clr) model_ovr = 1'b0;
    end else begin
      model_ovr = 1'b1;
    end
    rx_rdy  = 1'b0;
    ovr_clr = 1'b0;
    cyc();
    chk("done_one_cycle", 32'(rx_done), 32'd0);
    chk("count", 32'(count), 32'(sb.size()));
    chk("ovr", 32'(ovr), 32'(model_ovr));
    chk("irq", 32'(irq), 32'(sb.size() >= 8));
    chk("full", 32'(full), 32'(sb.size() == 16));
    chk("head", 32'(rd_data), 32'(sb[0]));
    $display("send %02h count=%0d ovr=%0b", d, count, ovr);
  endtask

  task automatic pop_one();
    logic [7:0] exp;
    exp = sb.pop_front();
    chk("pop_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("pop_count", 32'(count), 32'(sb.size()));
    $display("pop  %02h count=%0d", exp, count);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00};
    vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 5'd1, 8'h11};
    vecs[5] = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 8'h11};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b1, 5'd2, 8'h11};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 8'h11};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'h5A};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00};

    rst = 1'b0; rx_rdy = 1'b1; rx_data = 8'h3C; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    rst = 1'b1;
    cyc();
    chk("rel_done", 32'(rx_done), 32'd1);
    chk("rel_count", 32'(count), 32'd1);
    rx_rdy = 1'b0;
    cyc();
    chk("rel_done_fall", 32'(rx_done), 32'd0);
    sb.push_back(8'h3C);
    pop_one();
    chk("rel_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 10; i++) begin
      rx_rdy = vecs[i].rdy; rx_data = vecs[i].data; rd_en = vecs[i].rd;
      cyc();
      chk($sformatf("vec%0d_done", i), 32'(rx_done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rdd));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'd0);
      $display("vec%0d rdy=%0b rd=%0b done=%0b count=%0d rd_data=%02h", i,
               vecs[i].rdy, vecs[i].rd, rx_done, count, rd_data);
    end
    rx_rdy = 1'b0; rd_en = 1'b0;

    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);

    send(8'hEE, 1'b0);
    send(8'hEF, 1'b1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    model_ovr = 1'b0;
    chk("ovr_clr_alone", 32'(ovr), 32'd0);

    for (int i = 0; i < 4; i++) pop_one();
    for (int i = 16; i < 20; i++) send(8'(i), 1'b0);
    chk("wrap_full", 32'(full), 32'd1);

    chk("sim_head", 32'(rd_data), 32'(sb[0]));
    rx_rdy = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
    cyc();
    rx_rdy = 1'b0; rd_en = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h77);
    chk("sim_done", 32'(rx_done), 32'd1);
    chk("sim_count", 32'(count), 32'd16);
    chk("sim_ovr", 32'(ovr), 32'd0);
    chk("sim_head_next", 32'(rd_data), 32'(sb[0]));
    $display("simultaneous write 77 + pop count=%0d", count);
    cyc();

    while (sb.size() > 0) pop_one();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_irq", 32'(irq), 32'd0);
    chk("drain_rd_data", 32'(rd_data), 32'd0);

    rx_rdy = 1'b1; rx_data = 8'h99;
    cyc();
    chk("midack_done", 32'(rx_done), 32'd1);
    rst = 1'b0;
    #1;
    chk("midack_async_done", 32'(rx_done), 32'd0);
    chk("midack_async_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("midack_reaccept", 32'(rx_done), 32'd1);
    chk("midack_count", 32'(count), 32'd1);
    chk("midack_rd_data", 32'(rd_data), 32'h99);
    $display("reset mid-ACK, re-accepted %02h", rd_data);
    rx_rdy = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
